// File: rtl/iddr_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : iddr_word_aligner
// Purpose  : Gathers IDDR bit pairs into words and aligns them to a training
//            pattern by bit-slip (automatic), or by BITSLIP pulses (manual).
// Revision : 1.0 - initial release
// ============================================================================
module iddr_word_aligner #(
    parameter int                    WORD_WIDTH   = 8,
    parameter logic [WORD_WIDTH-1:0] SYNC_PATTERN = 8'hB4,
    parameter int                    LOCK_COUNT   = 4
) (
    input  logic                          SCLK,
    input  logic                          RST,
    input  logic                          Q0,
    input  logic                          Q1,
    input  logic                          ALIGN_EN,
    input  logic                          BITSLIP,
    output logic [WORD_WIDTH-1:0]         DATA,
    output logic                          DVALID,
    output logic                          LOCKED,
    output logic                          ALIGN_ERR,
    output logic [$clog2(WORD_WIDTH)-1:0] OFFSET
);
    localparam int OW  = $clog2(WORD_WIDTH);
    localparam int PCW = $clog2(WORD_WIDTH / 2);
    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int SCW = $clog2(2 * WORD_WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HUNT   = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    logic [2*WORD_WIDTH-1:0] r_hist;
    logic [PCW-1:0]          r_pc;
    logic [OW-1:0]           r_off;
    logic [WORD_WIDTH-1:0]   r_data;
    logic                    r_dvalid;
    logic                    r_err;
    logic [1:0]              r_state;
    logic [MCW-1:0]          r_match;
    logic [SCW-1:0]          r_scnt;

    logic [2*WORD_WIDTH-1:0] w_hist_next;
    logic [WORD_WIDTH-1:0]   w_word;
    logic                    w_wedge;
    logic                    w_is_sync;
    logic [1:0]              w_state_nx;
    logic [MCW-1:0]          w_match_nx;
    logic [SCW-1:0]          w_scnt_nx;
    logic                    w_err_nx;
    logic                    w_slip;
    logic                    w_miss;

    // Newest bit (Q1) lands at the LSB; the word window is taken from the
    // history including the pair arriving this edge.
    assign w_hist_next = {r_hist[2*WORD_WIDTH-3:0], Q0, Q1};
    assign w_word      = w_hist_next[r_off +: WORD_WIDTH];
    assign w_wedge     = (r_pc == PCW'(WORD_WIDTH / 2 - 1));
    assign w_is_sync   = (w_word == SYNC_PATTERN);

    always_comb begin
        w_state_nx = r_state;
        w_match_nx = r_match;
        w_scnt_nx  = r_scnt;
        w_err_nx   = r_err;
        w_slip     = 1'b0;
        w_miss     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_slip = BITSLIP;
                if (ALIGN_EN) begin
                    w_state_nx = S_HUNT;
                    w_match_nx = '0;
                    w_scnt_nx  = '0;
                end
            end
            default: begin
                if (!ALIGN_EN) begin
                    w_state_nx = S_IDLE;
                    w_match_nx = '0;
                    w_err_nx   = 1'b0;
                end else if (w_wedge) begin
                    case (r_state)
                        S_HUNT: begin
                            if (w_is_sync) begin
                                w_match_nx = MCW'(1);
                                if (LOCK_COUNT == 1) begin
                                    w_state_nx = S_LOCKED;
                                    w_scnt_nx  = '0;
                                end else begin
                                    w_state_nx = S_VERIFY;
                                end
                            end else begin
                                w_miss = 1'b1;
                            end
                        end
                        S_VERIFY: begin
                            if (w_is_sync) begin
                                w_match_nx = r_match + 1'b1;
                                if (r_match + 1'b1 == MCW'(LOCK_COUNT)) begin
                                    w_state_nx = S_LOCKED;
                                    w_scnt_nx  = '0;
                                end
                            end else begin
                                w_miss     = 1'b1;
                                w_state_nx = S_HUNT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        // A failed comparison slips; the slip count saturates at 2*W
        if (w_miss) begin
            w_slip = 1'b1;
            if (r_scnt != SCW'(2 * WORD_WIDTH)) begin
                w_scnt_nx = r_scnt + 1'b1;
            end
            if (r_scnt >= SCW'(2 * WORD_WIDTH - 1)) begin
                w_err_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            r_hist   <= '0;
            r_pc     <= '0;
            r_off    <= '0;
            r_data   <= '0;
            r_dvalid <= 1'b0;
            r_err    <= 1'b0;
            r_state  <= S_IDLE;
            r_match  <= '0;
            r_scnt   <= '0;
        end else begin
            r_hist   <= w_hist_next;
            r_pc     <= w_wedge ? '0 : r_pc + 1'b1;
            r_dvalid <= w_wedge;
            if (w_wedge) begin
                r_data <= w_word;
            end
            if (w_slip) begin
                r_off <= (r_off == OW'(WORD_WIDTH - 1)) ? '0 : r_off + 1'b1;
            end
            r_state <= w_state_nx;
            r_match <= w_match_nx;
            r_scnt  <= w_scnt_nx;
            r_err   <= w_err_nx;
        end
    end

    assign DATA      = r_data;
    assign DVALID    = r_dvalid;
    assign LOCKED    = (r_state == S_LOCKED);
    assign ALIGN_ERR = r_err;
    assign OFFSET    = r_off;

endmodule
`default_nettype wire

// File: tb/tb_iddr_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_iddr_word_aligner
// Purpose  : Randomised scoreboard bench for iddr_word_aligner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iddr_word_aligner;
    localparam int         W    = 8;
    localparam logic [7:0] SYNC = 8'hB4;
    localparam int         LC   = 4;

    logic         SCLK = 1'b0;
    logic         RST = 1'b1, Q0 = 1'b0, Q1 = 1'b0, ALIGN_EN = 1'b0, BITSLIP = 1'b0;
    logic [W-1:0] DATA;
    logic         DVALID, LOCKED, ALIGN_ERR;
    logic [2:0]   OFFSET;

    iddr_word_aligner #(.WORD_WIDTH(W), .SYNC_PATTERN(SYNC), .LOCK_COUNT(LC)) dut (
        .SCLK(SCLK), .RST(RST), .Q0(Q0), .Q1(Q1), .ALIGN_EN(ALIGN_EN),
        .BITSLIP(BITSLIP), .DATA(DATA), .DVALID(DVALID), .LOCKED(LOCKED),
        .ALIGN_ERR(ALIGN_ERR), .OFFSET(OFFSET)
    );

    always #5 SCLK = ~SCLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;
    bit zfill = 0;
    bit tx[$];

    // Reference model: bit list in arrival order plus abstract alignment state
    typedef enum {M_IDLE, M_HUNT, M_VERIFY, M_LOCKED} mstate_t;
    bit           m_bits[$];
    int           m_cyc, m_off, m_match, m_slips;
    bit           m_err;
    mstate_t      m_st;
    logic [W-1:0] exp_data;
    bit           exp_dv;
    logic [W-1:0] wq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] m_word(input int off);
        logic [W-1:0] w = '0;
        int n = m_bits.size();
        for (int i = 0; i < W; i++) begin
            int idx = n - 1 - off - i;
            w[i] = (idx >= 0) ? m_bits[idx] : 1'b0;
        end
        return w;
    endfunction

    task automatic model(input bit rst, input bit q0, input bit q1, input bit en, input bit slip);
        bit wedge, miss, do_slip;
        logic [W-1:0] word;
        if (rst) begin
            m_bits.delete(); wq.delete();
            m_cyc = 0; m_off = 0; m_match = 0; m_slips = 0; m_err = 0;
            m_st = M_IDLE; exp_data = '0; exp_dv = 0;
            return;
        end
        m_bits.push_back(q0); m_bits.push_back(q1);
        while (m_bits.size() > 4 * W) void'(m_bits.pop_front());
        wedge = (m_cyc % (W / 2)) == (W / 2 - 1);
        m_cyc++;
        word = m_word(m_off);
        exp_dv = wedge;
        if (wedge) begin
            exp_data = word;
            wq.push_back(word);
        end
        miss = 0; do_slip = 0;
        if (m_st == M_IDLE) begin
            do_slip = slip;
            if (en) begin m_st = M_HUNT; m_slips = 0; m_match = 0; end
        end else if (!en) begin
            m_st = M_IDLE; m_match = 0; m_err = 0;
        end else if (wedge && m_st == M_HUNT) begin
            if (word == SYNC) begin
                m_match = 1;
                if (LC == 1) begin m_st = M_LOCKED; m_slips = 0; end
                else m_st = M_VERIFY;
            end else miss = 1;
        end else if (wedge && m_st == M_VERIFY) begin
            if (word == SYNC) begin
                m_match++;
                if (m_match == LC) begin m_st = M_LOCKED; m_slips = 0; end
            end else begin
                miss = 1; m_st = M_HUNT;
            end
        end
        if (miss) begin
            do_slip = 1;
            if (m_slips < 2 * W) m_slips++;
            if (m_slips == 2 * W) m_err = 1;
        end
        if (do_slip) m_off = (m_off + 1) % W;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model
    task automatic cyc(input bit rst, input bit en, input bit slip);
        bit b0, b1;
        b0 = tx.size() ? tx.pop_front() : (zfill ? 1'b0 : 1'($urandom_range(0, 1)));
        b1 = tx.size() ? tx.pop_front() : (zfill ? 1'b0 : 1'($urandom_range(0, 1)));
        RST = rst; Q0 = b0; Q1 = b1; ALIGN_EN = en; BITSLIP = slip;
        @(posedge SCLK);
        model(rst, b0, b1, en, slip);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = W - 1; i >= 0; i--) tx.push_back(b[i]);
    endtask

    // Junk bits ahead of the repeating pattern; five junk bits put the
    // aligned window at OFFSET 3 after three slips.
    task automatic load_training(input int junk, input int reps);
        tx.delete();
        for (int i = 0; i < junk; i++) tx.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < reps; i++) push_byte(SYNC);
    endtask

    always @(negedge SCLK) begin
        if (mon_en) begin
            check("DVALID", DVALID, exp_dv);
            check("DATA", DATA, exp_data);
            check("LOCKED", LOCKED, m_st == M_LOCKED);
            check("ALIGN_ERR", ALIGN_ERR, m_err);
            check("OFFSET", OFFSET, m_off);
            if (DVALID === 1'b1) begin
                if (wq.size() == 0) check("word_queue_underflow", 1, 0);
                else check("word", DATA, wq.pop_front());
            end
        end
    end

    initial begin
        // Reset with random data
        cyc(1, 0, 0);
        mon_en = 1;
        cyc(1, 0, 0);

        // Raw deserialisation
        tx.delete(); push_byte(8'h3C); push_byte(8'hA5);
        repeat (8) cyc(0, 0, 0);

        // Automatic lock
        cyc(1, 0, 0);
        load_training(5, 8);
        repeat (28) cyc(0, 1, 0);
        check("lock_LOCKED", LOCKED, 1);
        check("lock_OFFSET", OFFSET, 3);
        repeat (8) cyc(0, 1, 0);
        check("lock_hold", LOCKED, 1);

        // No pattern: error after 16 slips, cleared by dropping ALIGN_EN
        tx.delete(); cyc(1, 0, 0);
        zfill = 1;
        repeat (60) cyc(0, 1, 0);
        check("err_early", ALIGN_ERR, 0);
        repeat (4) cyc(0, 1, 0);
        check("err_set", ALIGN_ERR, 1);
        check("err_nolock", LOCKED, 0);
        repeat (12) cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("err_clear", ALIGN_ERR, 0);
        zfill = 0;

        // Manual slip in IDLE, then an ignored slip in HUNT
        cyc(1, 0, 0);
        tx.delete(); push_byte(8'h3C); push_byte(8'hA5); push_byte(8'h3C);
        cyc(0, 0, 1);
        check("slip_idle", OFFSET, 1);
        repeat (11) cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 1);
        check("slip_hunt", OFFSET, 0);

        // Reset in VERIFY, then re-hunt from offset 0
        cyc(1, 0, 0);
        load_training(5, 8);
        repeat (20) cyc(0, 1, 0);
        cyc(1, 1, 0);
        check("rst_LOCKED", LOCKED, 0);
        check("rst_OFFSET", OFFSET, 0);
        load_training(5, 8);
        repeat (28) cyc(0, 1, 0);
        check("relock", LOCKED, 1);

        // Randomised traffic with injected training bursts
        begin
            bit en = 0;
            cyc(1, 0, 0);
            tx.delete();
            for (int c = 0; c < 3000; c++) begin
                if (tx.size() == 0 && $urandom_range(0, 3) == 0) begin
                    for (int j = 0; j < $urandom_range(0, 7); j++) tx.push_back(1'($urandom_range(0, 1)));
                    for (int j = 0; j < 8; j++) push_byte(SYNC);
                end
                if ($urandom_range(0, 59) == 0) en = ~en;
                cyc($urandom_range(0, 499) == 0, en, $urandom_range(0, 9) == 0);
            end
        end

        @(negedge SCLK); #1;
        check("queue_drained", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
